// File: rtl/sipo_receiver_pkg.sv
// Shared constants for the serial link: default word MSB index, counter sizing
// and the bit order used by both the transmitter and the receiver.
package sipo_receiver_pkg;

   localparam int unsigned width_default = 7;

   typedef enum logic {
      msb_first = 1'b0,
      lsb_first = 1'b1
   } bit_order_e;

   localparam bit_order_e bit_order = msb_first;

   // Bits needed to count 0..width inclusive
   function automatic int unsigned cnt_bits(input int unsigned width);
      return (width < 1) ? 1 : $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_receiver_if.sv
// Serial-side strobes plus the parallel valid/ready handshake of the receiver.
interface sipo_receiver_if
   import sipo_receiver_pkg::*;
#(
   parameter int unsigned width = width_default
);
   logic             serial_in;
   logic             en;
   logic             sync;
   logic             ready;
   logic             ovr_clr;
   logic [width:0]   parallel_out;
   logic             valid;
   logic             busy;
   logic             overrun;

   modport master (
      output serial_in, en, sync, ready, ovr_clr,
      input  parallel_out, valid, busy, overrun
   );

   modport slave (
      input  serial_in, en, sync, ready, ovr_clr,
      output parallel_out, valid, busy, overrun
   );
endinterface

// File: rtl/sipo_bit_counter.sv
// Modulo-(width+1) bit counter: sync clear beats enable, tc_c marks the last bit.
module sipo_bit_counter
   import sipo_receiver_pkg::*;
#(
   parameter int unsigned width = width_default
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   input  logic sclr,
   output logic tc_c,
   output logic busy
);
   localparam int unsigned cnt_w = cnt_bits(width);

   logic [cnt_w-1:0] cnt;
   logic [cnt_w-1:0] cnt_next;

   assign tc_c = (cnt == cnt_w'(width));

   always_comb begin
      cnt_next = cnt;
      if (sclr) begin
         cnt_next = '0;
      end else if (en) begin
         cnt_next = tc_c ? '0 : cnt + cnt_w'(1);
      end
   end

   // busy tracks the registered count so it is never a decode of the flops
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt  <= '0;
         busy <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         busy <= (cnt_next != '0);
      end
   end

endmodule

// File: rtl/sipo_receiver.sv
// Deserialises the link bit stream into (width+1)-bit words and offers each one
// on a registered valid/ready handshake, flagging overrun on an unconsumed word.
module sipo_receiver
   import sipo_receiver_pkg::*;
#(
   parameter int unsigned width = width_default
) (
   input  logic           clk,
   input  logic           clr,
   sipo_receiver_if.slave bus
);
   logic [width-1:0] sr;
   logic [width-1:0] shift_c;
   logic [width:0]   word_c;
   logic [width:0]   parallel_out;
   logic             valid;
   logic             overrun;
   logic             busy;
   logic             tc_c;
   logic             step_c;
   logic             done_c;
   logic             load_c;
   logic             ovr_set_c;

   sipo_bit_counter #(
      .width (width)
   ) u_cnt (
      .clk  (clk),
      .clr  (clr),
      .en   (bus.en),
      .sclr (bus.sync),
      .tc_c (tc_c),
      .busy (busy)
   );

   // Shift direction and final word assembly follow the shared bit order
   generate
      if (bit_order == msb_first) begin : g_msb
         if (width == 1) begin : g_one
            assign shift_c = bus.serial_in;
         end else begin : g_many
            assign shift_c = {sr[width-2:0], bus.serial_in};
         end
         assign word_c = {sr, bus.serial_in};
      end else begin : g_lsb
         if (width == 1) begin : g_one
            assign shift_c = bus.serial_in;
         end else begin : g_many
            assign shift_c = {bus.serial_in, sr[width-1:1]};
         end
         assign word_c = {bus.serial_in, sr};
      end
   endgenerate

   assign step_c    = bus.en && !bus.sync;
   assign done_c    = step_c && tc_c;
   assign load_c    = done_c && (!valid || bus.ready);
   assign ovr_set_c = done_c && valid && !bus.ready;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         sr           <= '0;
         parallel_out <= '0;
         valid        <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (bus.sync) begin
            sr <= '0;
         end else if (step_c) begin
            sr <= tc_c ? '0 : shift_c;
         end

         // A completing word may replace one being accepted on the same edge
         if (load_c) begin
            parallel_out <= word_c;
            valid        <= 1'b1;
         end else if (valid && bus.ready) begin
            valid <= 1'b0;
         end

         if (ovr_set_c) begin
            overrun <= 1'b1;
         end else if (bus.ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

   assign bus.parallel_out = parallel_out;
   assign bus.valid        = valid;
   assign bus.busy         = busy;
   assign bus.overrun      = overrun;

endmodule

// File: tb/tb_sipo_receiver.sv
// Directed bench for sipo_receiver at width=7: vector table plus corner sequences.
module tb_sipo_receiver;
   import sipo_receiver_pkg::*;

   typedef struct {
      logic       en;
      logic       sync;
      logic       sin;
      logic       ready;
      logic       ovr_clr;
      logic [7:0] po;
      logic       valid;
      logic       busy;
      logic       ovr;
      string      name;
   } vec_t;

   logic clk = 1'b0;
   logic clr;
   int   total = 0;
   int   bad   = 0;
   vec_t vecs[$];

   sipo_receiver_if #(.width(7)) bus ();

   sipo_receiver #(.width(7)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic [7:0] po, input logic v,
                          input logic b, input logic o);
      chk({nm, ".parallel_out"}, 32'(bus.parallel_out), 32'(po));
      chk({nm, ".valid"},        32'(bus.valid),        32'(v));
      chk({nm, ".busy"},         32'(bus.busy),         32'(b));
      chk({nm, ".overrun"},      32'(bus.overrun),      32'(o));
   endtask

   task automatic drive(input logic e, input logic s, input logic d, input logic r, input logic oc);
      bus.en = e; bus.sync = s; bus.serial_in = d; bus.ready = r; bus.ovr_clr = oc;
   endtask

   // Eight strobed bits of w; expected outputs after bits 1-7 and after bit 8
   task automatic add_word(input string nm, input logic [7:0] w,
                           input logic rdy_mid, input logic rdy_last,
                           input logic [7:0] po_mid, input logic v_mid, input logic o_mid,
                           input logic [7:0] po_end, input logic v_end, input logic o_end);
      for (int i = 0; i < 8; i++) begin
         vec_t v;
         v.en = 1'b1; v.sync = 1'b0; v.sin = w[7-i]; v.ovr_clr = 1'b0;
         v.ready = (i == 7) ? rdy_last : rdy_mid;
         if (i < 7) begin
            v.po = po_mid; v.valid = v_mid; v.busy = 1'b1; v.ovr = o_mid;
         end else begin
            v.po = po_end; v.valid = v_end; v.busy = 1'b0; v.ovr = o_end;
         end
         v.name = $sformatf("%s_b%0d", nm, i);
         vecs.push_back(v);
      end
   endtask

   task automatic add_idle(input string nm, input logic r, input logic oc,
                           input logic [7:0] po, input logic v_exp, input logic o_exp);
      vec_t v;
      v.en = 1'b0; v.sync = 1'b0; v.sin = 1'b0; v.ready = r; v.ovr_clr = oc;
      v.po = po; v.valid = v_exp; v.busy = 1'b0; v.ovr = o_exp; v.name = nm;
      vecs.push_back(v);
   endtask

   task automatic send_word(input logic [7:0] w, input logic r);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, w[7-i], r, 1'b0);
         cyc();
      end
      drive(1'b0, 1'b0, 1'b0, r, 1'b0);
   endtask

   initial begin
      logic [7:0] a5;
      logic [7:0] words [4];
      logic [7:0] got[$];
      int gaps;

      a5 = 8'hA5;
      words = '{8'h12, 8'h34, 8'h56, 8'h78};

      add_word("basic",  8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
      add_word("ovr",    8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
      add_idle("ovr_clr",        1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
      add_idle("take",           1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
      add_word("refill", 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
      add_word("accept", 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0);
      add_idle("take2",          1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
      add_idle("ready_idle",     1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);

      // Power-on reset
      clr = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(); cyc();
      chk_out("por", 8'h00, 1'b0, 1'b0, 1'b0);
      clr = 1'b1;

      foreach (vecs[k]) begin
         drive(vecs[k].en, vecs[k].sync, vecs[k].sin, vecs[k].ready, vecs[k].ovr_clr);
         cyc();
         chk_out(vecs[k].name, vecs[k].po, vecs[k].valid, vecs[k].busy, vecs[k].ovr);
      end

      // Gapped strobes, serial_in driven X during gaps
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, a5[7-i], 1'b0, 1'b0);
         cyc();
         if (i < 7) begin
            gaps = $urandom_range(1, 3);
            for (int g = 0; g < gaps; g++) begin
               drive(1'b0, 1'b0, 1'bx, 1'b0, 1'b0);
               cyc();
               chk($sformatf("gap_b%0d_g%0d.busy", i, g), 32'(bus.busy), 32'd1);
            end
         end
      end
      chk_out("gapped", 8'hA5, 1'b1, 1'b0, 1'b0);

      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();
      chk("drain.valid", 32'(bus.valid), 32'd0);

      // Back-to-back stream with ready held high
      for (int w = 0; w < 4; w++) begin
         for (int i = 0; i < 8; i++) begin
            if (bus.valid && bus.ready) got.push_back(bus.parallel_out);
            drive(1'b1, 1'b0, words[w][7-i], 1'b1, 1'b0);
            cyc();
         end
         chk($sformatf("stream_w%0d.parallel_out", w), 32'(bus.parallel_out), 32'(words[w]));
         chk($sformatf("stream_w%0d.valid", w), 32'(bus.valid), 32'd1);
      end
      if (bus.valid && bus.ready) got.push_back(bus.parallel_out);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();
      chk("stream.valid_end", 32'(bus.valid), 32'd0);
      chk("stream.overrun", 32'(bus.overrun), 32'd0);
      chk("stream.count", 32'(got.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("stream.seen%0d", k), (k < got.size()) ? 32'(got[k]) : 32'hFFFF, 32'(words[k]));
      end

      // Realign: 3 stray bits, then sync with en, then 0x81
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         cyc();
      end
      chk("pre_sync.busy", 32'(bus.busy), 32'd1);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc();
      chk("sync.busy", 32'(bus.busy), 32'd0);
      chk("sync.valid", 32'(bus.valid), 32'd0);
      send_word(8'h81, 1'b0);
      chk_out("realign", 8'h81, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset mid-word with overrun set
      send_word(8'h3C, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         cyc();
      end
      chk_out("pre_rst", 8'h81, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      clr = 1'b0;
      #1;
      chk_out("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      clr = 1'b1;
      send_word(8'hF0, 1'b0);
      chk_out("post_rst", 8'hF0, 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
